// File: rtl/fft_r22sdf_bfii_stage.sv
// rtl/fft_r22sdf_bfii_stage.sv - self-sequencing radix-2^2 SDF butterfly-II stage (optional FFT_R22SDF_BFII_ROUND_EN)
module fft_r22sdf_bfii_stage #(
    parameter int DATA_WIDTH    = 25,
    parameter int SHIFT_REG_LEN = 256,
    parameter int SCALE         = 0,
    localparam int OW           = (SCALE != 0) ? DATA_WIDTH : DATA_WIDTH + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic                         sync_i,
    input  logic                         inv_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic signed [OW-1:0]         z_re_o,
    output logic signed [OW-1:0]         z_im_o,
    output logic                         valid_o,
    output logic                         sync_o
);
    localparam int IW = DATA_WIDTH + 1;
    localparam int CW = $clog2(4 * SHIFT_REG_LEN);

    logic [CW-1:0]        cnt_q, cnt_d, cur_cnt;
    logic [1:0]           phase;
    logic                 primed_q, primed_d, primed_eff;
    logic                 valid_d, sync_d;
    logic signed [IW-1:0] sr_re_q [SHIFT_REG_LEN];
    logic signed [IW-1:0] sr_im_q [SHIFT_REG_LEN];
    logic signed [IW-1:0] x_re, x_im, xr_re, xr_im;
    logic signed [IW-1:0] sr_re, sr_im;
    logic signed [IW-1:0] sum_re, sum_im, dl_re, dl_im;
    logic signed [OW-1:0] z_re_d, z_im_d;

    assign sr_re = sr_re_q[SHIFT_REG_LEN-1];
    assign sr_im = sr_im_q[SHIFT_REG_LEN-1];

    // Frame position and primed tracking; a synced sample is forced to index 0.
    always_comb begin
        cur_cnt    = (valid_i && sync_i) ? '0 : cnt_q;
        phase      = cur_cnt[CW-1 -: 2];
        cnt_d      = valid_i ? cur_cnt + CW'(1) : cnt_q;
        primed_eff = primed_q && !(valid_i && sync_i);
        primed_d   = valid_i ? (primed_eff || phase == 2'd1) : primed_q;
        valid_d    = valid_i && (primed_eff || phase == 2'd1);
        sync_d     = valid_i && (cur_cnt == CW'(SHIFT_REG_LEN));
    end

    // Butterfly datapath: load, plain add/sub, or add/sub against the +/-j rotated input.
    always_comb begin
        x_re  = IW'(x_re_i);
        x_im  = IW'(x_im_i);
        xr_re = inv_i ? -x_im : x_im;
        xr_im = inv_i ? x_re : -x_re;
        sum_re = sr_re;
        sum_im = sr_im;
        dl_re  = x_re;
        dl_im  = x_im;
        case (phase)
            2'd1: begin
                sum_re = sr_re + x_re;
                sum_im = sr_im + x_im;
                dl_re  = sr_re - x_re;
                dl_im  = sr_im - x_im;
            end
            2'd3: begin
                sum_re = sr_re + xr_re;
                sum_im = sr_im + xr_im;
                dl_re  = sr_re - xr_re;
                dl_im  = sr_im - xr_im;
            end
            default: ;
        endcase
    end

    generate
        if (SCALE != 0) begin : g_scale
`ifdef FFT_R22SDF_BFII_ROUND_EN
            logic signed [IW:0] rnd_re, rnd_im;
            // Halve with round-half-up, computed one bit wider so the +1 cannot wrap.
            always_comb begin
                rnd_re = $signed({sum_re[IW-1], sum_re}) + (IW+1)'(1);
                rnd_im = $signed({sum_im[IW-1], sum_im}) + (IW+1)'(1);
                z_re_d = OW'(rnd_re >>> 1);
                z_im_d = OW'(rnd_im >>> 1);
            end
`else
            // Halve by arithmetic shift, truncating toward minus infinity.
            always_comb begin
                z_re_d = OW'(sum_re >>> 1);
                z_im_d = OW'(sum_im >>> 1);
            end
`endif
        end else begin : g_full
            // Full precision: the one bit of growth is carried to the output.
            always_comb begin
                z_re_d = sum_re;
                z_im_d = sum_im;
            end
        end
    endgenerate

    // Feedback delay line; advances only on accepted samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SHIFT_REG_LEN; i++) begin
                sr_re_q[i] <= '0;
                sr_im_q[i] <= '0;
            end
        end else if (valid_i) begin
            sr_re_q[0] <= dl_re;
            sr_im_q[0] <= dl_im;
            for (int i = 1; i < SHIFT_REG_LEN; i++) begin
                sr_re_q[i] <= sr_re_q[i-1];
                sr_im_q[i] <= sr_im_q[i-1];
            end
        end
    end

    // Control state and registered outputs; z holds across input gaps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            valid_o  <= 1'b0;
            sync_o   <= 1'b0;
            z_re_o   <= '0;
            z_im_o   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            valid_o  <= valid_d;
            sync_o   <= sync_d;
            if (valid_i) begin
                z_re_o <= z_re_d;
                z_im_o <= z_im_d;
            end
        end
    end
endmodule
